// File: rtl/mode_switch_controller.sv
// Mode sequencer: synchronizes and debounces three raw mode switches, enforces the
// exactly-one-switch rule, and commits a new mode only after a req/ack handshake.
module mode_switch_controller #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch_1,
    input  logic       switch_2,
    input  logic       switch_3,
    input  logic       change_ack,
    output logic       mod_1,
    output logic       mod_2,
    output logic       mod_3,
    output logic       change_req,
    output logic [2:0] pending_mode,
    output logic       mode_change
);

    typedef enum logic [1:0] {STABLE, SETTLE, REQ} state_t;

    localparam logic [7:0] DB = 8'(DEBOUNCE);

    state_t     state, state_n;
    logic [2:0] s1, s2, cand;
    logic [2:0] mod, mod_n;
    logic [2:0] pending, pending_n;
    logic [7:0] cnt, cnt_n;
    logic       req_n, mc_n;
    logic [2:0] pmode_n;

    always_comb begin
        cand = '0;
        unique case (s2)
            3'b001, 3'b010, 3'b100: cand = s2;
            default:                cand = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= '0;
            s2           <= '0;
            state        <= STABLE;
            mod          <= '0;
            pending      <= '0;
            cnt          <= '0;
            change_req   <= 1'b0;
            pending_mode <= '0;
            mode_change  <= 1'b0;
        end else begin
            s1           <= {switch_3, switch_2, switch_1};
            s2           <= s1;
            state        <= state_n;
            mod          <= mod_n;
            pending      <= pending_n;
            cnt          <= cnt_n;
            change_req   <= req_n;
            pending_mode <= pmode_n;
            mode_change  <= mc_n;
        end
    end

    always_comb begin
        state_n   = state;
        mod_n     = mod;
        pending_n = pending;
        cnt_n     = cnt;
        unique case (state)
            STABLE: begin
                if (cand != mod) begin
                    pending_n = cand;
                    cnt_n     = 8'd1;
                    state_n   = SETTLE;
                end
            end
            SETTLE: begin
                if (cand == mod) begin
                    state_n = STABLE;
                end else if (cand != pending) begin
                    pending_n = cand;
                    cnt_n     = 8'd1;
                end else if (cnt == DB) begin
                    state_n = REQ;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            REQ: begin
                if (change_ack) begin
                    mod_n   = pending;
                    state_n = STABLE;
                end
            end
            default: state_n = STABLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight off flops.
    always_comb begin
        req_n   = (state_n == REQ);
        pmode_n = req_n ? pending_n : '0;
        mc_n    = (state == REQ) && change_ack;
    end

    assign mod_1 = mod[0];
    assign mod_2 = mod[1];
    assign mod_3 = mod[2];

endmodule

// File: tb/tb_mode_switch_controller.sv
// Scoreboard bench for mode_switch_controller: expected requests and commits are
// queued when stimulus is driven and checked when the DUT raises them.
module tb_mode_switch_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       switch_1 = 1'b0, switch_2 = 1'b0, switch_3 = 1'b0;
    logic       change_ack = 1'b0;
    logic       mod_1, mod_2, mod_3;
    logic       change_req;
    logic [2:0] pending_mode;
    logic       mode_change;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [2:0]  req_q[$];
    logic [2:0]  commit_q[$];
    logic        prev_req = 1'b0;
    logic        prev_mc = 1'b0;

    wire [2:0] mod = {mod_3, mod_2, mod_1};

    mode_switch_controller #(.DEBOUNCE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .switch_1    (switch_1),
        .switch_2    (switch_2),
        .switch_3    (switch_3),
        .change_ack  (change_ack),
        .mod_1       (mod_1),
        .mod_2       (mod_2),
        .mod_3       (mod_3),
        .change_req  (change_req),
        .pending_mode(pending_mode),
        .mode_change (mode_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each rising change_req and each mode_change pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
            prev_mc  = 1'b0;
        end else begin
            if (change_req && !prev_req) begin
                check("req_expected", 8'(req_q.size() != 0), 8'd1);
                if (req_q.size() != 0) check("req_pending", 8'(pending_mode), 8'(req_q.pop_front()));
            end
            if (mode_change) begin
                check("mc_width", 8'(prev_mc), 8'd0);
                check("commit_expected", 8'(commit_q.size() != 0), 8'd1);
                if (commit_q.size() != 0) check("commit_mod", 8'(mod), 8'(commit_q.pop_front()));
            end
            check("mod_onehot", 8'($countones(mod) <= 1), 8'd1);
            prev_req = change_req;
            prev_mc  = mode_change;
        end
    end

    // Edge-by-edge latency check, starting with switches already driven before edge 1.
    task automatic run_latency(input logic [2:0] exp);
        for (int n = 1; n <= 9; n++) begin
            tick();
            check($sformatf("lat_req_e%0d", n), 8'(change_req), 8'(n == 7));
            check($sformatf("lat_mc_e%0d", n), 8'(mode_change), 8'(n == 8));
            if (n == 7) check("lat_pending", 8'(pending_mode), 8'(exp));
            if (n == 8) check("lat_mod", 8'(mod), 8'(exp));
        end
    endtask

    task automatic wait_req();
        int unsigned k = 0;
        while (!change_req && k < 30) begin
            tick();
            k++;
        end
        check("req_timeout", 8'(change_req), 8'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_mod", 8'(mod), 8'd0);
        check("rst_req", 8'(change_req), 8'd0);
        check("rst_pend", 8'(pending_mode), 8'd0);
        check("rst_mc", 8'(mode_change), 8'd0);
        repeat (3) @(posedge clk);

        // Basic commit of switch_2 with ack tied high.
        @(negedge clk);
        rst_n = 1'b1;
        switch_2 = 1'b1;
        change_ack = 1'b1;
        req_q.push_back(3'b010);
        commit_q.push_back(3'b010);
        run_latency(3'b010);

        // Bounce: switch_1 high for 3 cycles, then all low -> commit 000, never 001.
        @(negedge clk);
        switch_2 = 1'b0;
        switch_1 = 1'b1;
        req_q.push_back(3'b000);
        commit_q.push_back(3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        switch_1 = 1'b0;
        repeat (20) tick();
        check("bounce_mod", 8'(mod), 8'd0);

        // Reach mode 100, then two switches high commits 000.
        switch_3 = 1'b1;
        req_q.push_back(3'b100);
        commit_q.push_back(3'b100);
        repeat (14) tick();
        check("mode3_mod", 8'(mod), 8'b100);
        switch_1 = 1'b1;
        req_q.push_back(3'b000);
        commit_q.push_back(3'b000);
        repeat (14) tick();
        check("two_sw_mod", 8'(mod), 8'd0);

        // Held ack: REQ for 001 stays frozen while switches churn.
        change_ack = 1'b0;
        switch_3 = 1'b0;
        req_q.push_back(3'b001);
        commit_q.push_back(3'b001);
        wait_req();
        for (int i = 0; i < 20; i++) begin
            if (i < 17) begin
                {switch_3, switch_2, switch_1} = 3'($urandom_range(0, 7));
            end else begin
                {switch_3, switch_2, switch_1} = 3'b001;
            end
            tick();
            check("hold_req", 8'(change_req), 8'd1);
            check("hold_pend", 8'(pending_mode), 8'b001);
            check("hold_mod", 8'(mod), 8'd0);
            check("hold_mc", 8'(mode_change), 8'd0);
        end
        change_ack = 1'b1;
        tick();
        check("hold_commit_mc", 8'(mode_change), 8'd1);
        check("hold_commit_mod", 8'(mod), 8'b001);
        check("hold_commit_req", 8'(change_req), 8'd0);
        tick();
        check("hold_mc_low", 8'(mode_change), 8'd0);

        // Reset mid-REQ aborts; full latency repeats after release.
        change_ack = 1'b0;
        switch_1 = 1'b0;
        switch_2 = 1'b1;
        req_q.push_back(3'b010);
        wait_req();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreq_rst_mod", 8'(mod), 8'd0);
        check("midreq_rst_req", 8'(change_req), 8'd0);
        check("midreq_rst_pend", 8'(pending_mode), 8'd0);
        check("midreq_rst_mc", 8'(mode_change), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        change_ack = 1'b1;
        req_q.push_back(3'b010);
        commit_q.push_back(3'b010);
        run_latency(3'b010);

        // Ack pulses while STABLE must do nothing.
        for (int i = 0; i < 8; i++) begin
            change_ack = 1'(i % 2);
            tick();
            check("idle_ack_mc", 8'(mode_change), 8'd0);
            check("idle_ack_mod", 8'(mod), 8'b010);
            check("idle_ack_req", 8'(change_req), 8'd0);
        end

        tick();
        check("req_q_drained", 8'(req_q.size()), 8'd0);
        check("commit_q_drained", 8'(commit_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
